bsg_dmc_trace_pattern_gen: RTL and testbench
============================================

Name: bsg_dmc_trace_pattern_gen

Overview:
- Self-test traffic source and checker for the DMC pearl trace-replay port.
- Upstream: drives trace entries into the pearl trace input (trace_data/v/ready).
- Downstream: consumes read data returned on the pearl trace output (data/v/yumi).
- Writes an LFSR pattern over a configurable address range, reads it back, compares against the regenerated pattern, and reports pass/fail, error count and first failing address.

Parameters:
- data_width_p, 128, UI data width; a multiple of 32.
- addr_width_p, 28, UI address width.
- burst_len_p, 2, UI beats per DRAM burst.
- num_bursts_p, 64, bursts written then read per run; must be at least 1.
- addr_stride_p, 8, address increment per burst.
- seed_p, 32'hACE1_F00D, LFSR seed; must be non-zero.

Ports:
- clk_i  in  1  UI clock.
- reset_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  pulse; starts a run from IDLE or DONE.
- base_addr_i  in  addr_width_p  first burst address; sampled on start.
- trace_data_o  out  trace_entry_width  packed entry {cmd, addr, mask, data}.
- trace_v_o  out  1  entry valid.
- trace_ready_i  in  1  pearl can accept an entry.
- trace_data_i  in  data_width_p  returned read beat.
- trace_v_i  in  1  read beat valid.
- trace_yumi_o  out  1  read beat consumed.
- busy_o  out  1  run in progress.
- done_o  out  1  run finished; held until next start.
- pass_o  out  1  done and error_count_o == 0.
- error_count_o  out  16  mismatching beats, saturating.
- first_err_addr_o  out  addr_width_p  burst address of first mismatch.

Behaviour:
- Reset: all outputs 0; FSM IDLE; both LFSRs = seed_p; counters 0. Reset is asynchronous and may assert mid-run; on release the block returns to IDLE and does not resume.
- FSM states:
  - IDLE: on start_i, latch base_addr_i, clear error state, go to WRITE.
  - WRITE: emit burst_len_p entries per burst. cmd=WR, addr = base + burst*addr_stride_p, mask=0, data = write-LFSR word replicated data_width_p/32 times. LFSR advances on each accepted beat (trace_v_o & trace_ready_i). After num_bursts_p*burst_len_p accepted beats, go to READ.
  - READ: emit one entry per burst; cmd=RD, same address sequence, data=0. Continue accepting returned beats concurrently. After num_bursts_p accepted entries, go to DRAIN.
  - DRAIN: wait until num_bursts_p*burst_len_p beats have been received, then go to DONE.
  - DONE: done_o=1; start_i restarts the run as from IDLE.
- Output handshake: valid/ready. trace_v_o is held, and data is stable, until accepted. trace_v_o never depends combinationally on trace_ready_i.
- Input handshake: trace_yumi_o = trace_v_i in READ or DRAIN, else 0. Beats arriving in any other state are not consumed.
- Checker: check-LFSR is reseeded on entry to WRITE and advances per consumed beat. A mismatch increments error_count_o, saturating at 16'hFFFF. On the first mismatch, first_err_addr_o captures the address of the burst that beat belongs to (rx_beat / burst_len_p).
- Latency:
  - start_i to first trace_v_o: 1 cycle.
  - Last consumed beat to done_o: 1 cycle.
- Boundary cases:
  - Address arithmetic wraps modulo 2^addr_width_p.
  - start_i while busy is ignored.
  - Simultaneous final write acceptance and start_i: no effect.
  - Beat receive and entry send in the same cycle are both processed.
- Commands use app_cmd_e encodings (WR, RD).

Optional Feature:
- Macro BSG_DMC_TRACE_PATTERN_ERR_INJECT_EN.
- When defined:
  - Adds input inject_err_i (1 bit), sampled on start.
  - If the sample is set, bit 0 of the first written beat is inverted. Expected result: error_count_o=1, first_err_addr_o=base.
- When undefined: the port is absent and data is never modified.

Decomposition:
- Shared package bsg_dmc_pearl_pkg:
  - trace_gen_state_e (IDLE, WRITE, READ, DRAIN, DONE).
  - Trace entry struct macro (cmd, addr, mask, data) and its width macro.
  - LFSR tap constant 32'h8020_0003.
- One sub-module, bsg_dmc_pattern_lfsr:
  - 32-bit Galois LFSR with seed load and advance enable.
  - Instanced twice: write side and check side.

Test Plan:
- Loopback memory model, num_bursts_p=4, base=0x100, stride=8: 8 WR entries at 0x100,0x100,0x108,0x108,… then 4 RD entries; done_o=1, pass_o=1, error_count_o=0.
- Model flips one bit in the read beat of burst 2 → error_count_o=1, first_err_addr_o=0x110, pass_o=0.
- trace_ready_i random 30% duty → entry sequence identical to the no-stall run; trace_data_o held stable while stalled.
- base=2^28-8, num_bursts_p=2 → second burst address wraps to 0x0000000.
- Assert reset_n_i low during READ → all outputs 0 immediately; a fresh start completes with pass_o=1.
- With BSG_DMC_TRACE_PATTERN_ERR_INJECT_EN and inject_err_i=1 → error_count_o=1, first_err_addr_o=base.

Source files
------------

// File: rtl/bsg_dmc_pearl_pkg.sv
// Shared pearl trace-port types: app commands, trace-gen FSM states, LFSR taps and entry layout.
// Entry macros sit beside the package so every pearl-side block agrees on the packed layout.
`ifndef BSG_DMC_PEARL_PKG_SV
`define BSG_DMC_PEARL_PKG_SV

package bsg_dmc_pearl_pkg;

  typedef enum logic [2:0] {
    WR = 3'b000,
    RD = 3'b001
  } app_cmd_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } trace_gen_state_e;

  localparam logic [31:0] lfsr_taps_gp = 32'h8020_0003;

endpackage

`define BSG_DMC_TRACE_ENTRY_WIDTH(addr_width_mp, data_width_mp) \
  (3 + (addr_width_mp) + ((data_width_mp) / 8) + (data_width_mp))

`define DECLARE_BSG_DMC_TRACE_ENTRY_S(addr_width_mp, data_width_mp) \
  typedef struct packed { \
    bsg_dmc_pearl_pkg::app_cmd_e     cmd; \
    logic [(addr_width_mp)-1:0]      addr; \
    logic [((data_width_mp)/8)-1:0]  mask; \
    logic [(data_width_mp)-1:0]      data; \
  } bsg_dmc_trace_entry_s

`endif

// File: rtl/bsg_dmc_pattern_lfsr.sv
// 32-bit right-shifting Galois LFSR; load_i restores the seed, en_i advances one step.
// Output is registered: the new word is visible the cycle after load/advance.
module bsg_dmc_pattern_lfsr
  import bsg_dmc_pearl_pkg::*;
#(
  parameter logic [31:0] seed_p = 32'hACE1_F00D
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        load_i,
  input  logic        en_i,
  output logic [31:0] lfsr_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lfsr_o <= seed_p;
    end else if (load_i) begin
      lfsr_o <= seed_p;
    end else if (en_i) begin
      lfsr_o <= {1'b0, lfsr_o[31:1]} ^ (lfsr_o[0] ? lfsr_taps_gp : 32'h0);
    end
  end

endmodule

// File: rtl/bsg_dmc_trace_pattern_gen.sv
// Pearl trace-port self test: writes an LFSR pattern, reads it back and checks it; start to first entry 1 cycle.
// Entries held until trace_ready_i; beats consumed only in READ/DRAIN. BSG_DMC_TRACE_PATTERN_ERR_INJECT_EN adds inject_err_i.
module bsg_dmc_trace_pattern_gen
  import bsg_dmc_pearl_pkg::*;
#(
  parameter int          data_width_p  = 128,
  parameter int          addr_width_p  = 28,
  parameter int          burst_len_p   = 2,
  parameter int          num_bursts_p  = 64,
  parameter int          addr_stride_p = 8,
  parameter logic [31:0] seed_p        = 32'hACE1_F00D
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_i,
  input  logic [addr_width_p-1:0] base_addr_i,
`ifdef BSG_DMC_TRACE_PATTERN_ERR_INJECT_EN
  input  logic                    inject_err_i,
`endif
  output logic [`BSG_DMC_TRACE_ENTRY_WIDTH(addr_width_p, data_width_p)-1:0] trace_data_o,
  output logic                    trace_v_o,
  input  logic                    trace_ready_i,
  input  logic [data_width_p-1:0] trace_data_i,
  input  logic                    trace_v_i,
  output logic                    trace_yumi_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [15:0]             error_count_o,
  output logic [addr_width_p-1:0] first_err_addr_o
);

  `DECLARE_BSG_DMC_TRACE_ENTRY_S(addr_width_p, data_width_p);

  localparam int burst_w_lp = (num_bursts_p > 1) ? $clog2(num_bursts_p) : 1;
  localparam int beat_w_lp  = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam int words_lp   = data_width_p / 32;
  localparam logic [addr_width_p-1:0] stride_lp = addr_width_p'(addr_stride_p);

  trace_gen_state_e state_r, state_n;
  bsg_dmc_trace_entry_s entry;

  logic [addr_width_p-1:0] base_r, tx_addr_r, rx_addr_r;
  logic [burst_w_lp-1:0]   tx_burst_r, rx_burst_r;
  logic [beat_w_lp-1:0]    tx_beat_r, rx_beat_r;
  logic                    rx_all_r, inj_r;
  logic [31:0]             wr_word, chk_word;

  logic start_ok, tx_fire, rx_fire, mismatch, inj_first;
  logic tx_last_beat, tx_last_burst, rx_last_beat, rx_last_burst, rx_last;

  assign start_ok      = start_i & ((state_r == IDLE) | (state_r == DONE));
  assign tx_fire       = trace_v_o & trace_ready_i;
  assign rx_fire       = trace_yumi_o;
  assign tx_last_beat  = (tx_beat_r == beat_w_lp'(burst_len_p - 1));
  assign tx_last_burst = (tx_burst_r == burst_w_lp'(num_bursts_p - 1));
  assign rx_last_beat  = (rx_beat_r == beat_w_lp'(burst_len_p - 1));
  assign rx_last_burst = (rx_burst_r == burst_w_lp'(num_bursts_p - 1));
  assign rx_last       = rx_fire & rx_last_beat & rx_last_burst;
  assign mismatch      = rx_fire & (trace_data_i != {words_lp{chk_word}});
  assign inj_first     = inj_r & (state_r == WRITE) & (tx_burst_r == '0) & (tx_beat_r == '0);

  bsg_dmc_pattern_lfsr #(.seed_p(seed_p)) wr_lfsr (
    .clk_i, .reset_n_i, .load_i(start_ok), .en_i(tx_fire & (state_r == WRITE)), .lfsr_o(wr_word)
  );

  bsg_dmc_pattern_lfsr #(.seed_p(seed_p)) chk_lfsr (
    .clk_i, .reset_n_i, .load_i(start_ok), .en_i(rx_fire), .lfsr_o(chk_word)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE, DONE: if (start_i) state_n = WRITE;
      WRITE:      if (tx_fire & tx_last_beat & tx_last_burst) state_n = READ;
      READ:       if (tx_fire & tx_last_burst) state_n = DRAIN;
      DRAIN:      if (rx_all_r | rx_last) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_comb begin
    trace_v_o    = (state_r == WRITE) | (state_r == READ);
    trace_yumi_o = trace_v_i & ((state_r == READ) | (state_r == DRAIN));
    busy_o       = (state_r == WRITE) | (state_r == READ) | (state_r == DRAIN);
    done_o       = (state_r == DONE);
    pass_o       = (state_r == DONE) & (error_count_o == 16'h0);
  end

  always_comb begin
    entry = '0;
    if (state_r == WRITE) begin
      entry.cmd  = WR;
      entry.addr = tx_addr_r;
      entry.data = {words_lp{wr_word}} ^ {{(data_width_p-1){1'b0}}, inj_first};
    end else if (state_r == READ) begin
      entry.cmd  = RD;
      entry.addr = tx_addr_r;
    end
  end
  assign trace_data_o = entry;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      base_r           <= '0;
      tx_addr_r        <= '0;
      rx_addr_r        <= '0;
      tx_burst_r       <= '0;
      rx_burst_r       <= '0;
      tx_beat_r        <= '0;
      rx_beat_r        <= '0;
      rx_all_r         <= 1'b0;
      error_count_o    <= '0;
      first_err_addr_o <= '0;
    end else if (start_ok) begin
      base_r           <= base_addr_i;
      tx_addr_r        <= base_addr_i;
      rx_addr_r        <= base_addr_i;
      tx_burst_r       <= '0;
      rx_burst_r       <= '0;
      tx_beat_r        <= '0;
      rx_beat_r        <= '0;
      rx_all_r         <= 1'b0;
      error_count_o    <= '0;
      first_err_addr_o <= '0;
    end else begin
      // Write bursts step the address after the last beat; the read pass restarts at base.
      if (tx_fire) begin
        if (state_r == WRITE) begin
          if (tx_last_beat) begin
            tx_beat_r <= '0;
            if (tx_last_burst) begin
              tx_burst_r <= '0;
              tx_addr_r  <= base_r;
            end else begin
              tx_burst_r <= tx_burst_r + burst_w_lp'(1);
              tx_addr_r  <= tx_addr_r + stride_lp;
            end
          end else begin
            tx_beat_r <= tx_beat_r + beat_w_lp'(1);
          end
        end else begin
          tx_burst_r <= tx_burst_r + burst_w_lp'(1);
          tx_addr_r  <= tx_addr_r + stride_lp;
        end
      end
      if (rx_fire) begin
        if (rx_last_beat) begin
          rx_beat_r  <= '0;
          rx_burst_r <= rx_burst_r + burst_w_lp'(1);
          rx_addr_r  <= rx_addr_r + stride_lp;
        end else begin
          rx_beat_r <= rx_beat_r + beat_w_lp'(1);
        end
        if (rx_last) rx_all_r <= 1'b1;
        if (mismatch) begin
          if (error_count_o != 16'hFFFF) error_count_o <= error_count_o + 16'd1;
          if (error_count_o == 16'h0)    first_err_addr_o <= rx_addr_r;
        end
      end
    end
  end

`ifdef BSG_DMC_TRACE_PATTERN_ERR_INJECT_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)    inj_r <= 1'b0;
    else if (start_ok) inj_r <= inject_err_i;
  end
`else
  assign inj_r = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_dmc_trace_pattern_gen.sv
// Randomized bench for bsg_dmc_trace_pattern_gen: loopback memory model, expected entry stream built
// from the pattern rules, immediate assertions at each comparison point.
module tb_bsg_dmc_trace_pattern_gen;

  localparam int DW = 128;
  localparam int AW = 28;
  localparam int BL = 2;
  localparam int NB = 4;
  localparam int STRIDE = 8;
  localparam logic [31:0] SEED = 32'hACE1_F00D;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam int EW = 3 + AW + DW / 8 + DW;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
`ifdef BSG_DMC_TRACE_PATTERN_ERR_INJECT_EN
  logic          inject_err_i;
`endif
  logic [EW-1:0] trace_data_o;
  logic          trace_v_o;
  logic          trace_ready_i;
  logic [DW-1:0] trace_data_i;
  logic          trace_v_i;
  logic          trace_yumi_o;
  logic          busy_o, done_o, pass_o;
  logic [15:0]   error_count_o;
  logic [AW-1:0] first_err_addr_o;

  bsg_dmc_trace_pattern_gen #(
    .data_width_p(DW), .addr_width_p(AW), .burst_len_p(BL),
    .num_bursts_p(NB), .addr_stride_p(STRIDE), .seed_p(SEED)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .base_addr_i(base_addr_i),
`ifdef BSG_DMC_TRACE_PATTERN_ERR_INJECT_EN
    .inject_err_i(inject_err_i),
`endif
    .trace_data_o(trace_data_o), .trace_v_o(trace_v_o), .trace_ready_i(trace_ready_i),
    .trace_data_i(trace_data_i), .trace_v_i(trace_v_i), .trace_yumi_o(trace_yumi_o),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .error_count_o(error_count_o), .first_err_addr_o(first_err_addr_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] got_q[$];
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] mem[bit [31:0]];
  int            wr_seen, rd_seen, cyc, last_yumi_cyc, ready_pct, corrupt_burst;
  bit            hammer, prev_stall;
  logic [EW-1:0] prev_dat;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_word(input int n);
    logic [31:0] x = SEED;
    for (int i = 0; i < n; i++) x = (x >> 1) ^ (x[0] ? TAPS : 32'h0);
    return x;
  endfunction

  function automatic logic [EW-1:0] mk_entry(input logic [2:0] cmd, input logic [AW-1:0] a,
                                             input logic [DW-1:0] d);
    return {cmd, a, 16'h0, d};
  endfunction

  // Loopback memory: writes land in mem, each read entry queues burst_len return beats.
  task automatic model_accept(input logic [EW-1:0] e);
    logic [2:0]    cmd = e[EW-1 -: 3];
    logic [AW-1:0] a = e[EW-4 -: AW];
    logic [DW-1:0] d;
    if (cmd == 3'd0) begin
      mem[{a, 4'(wr_seen % BL)}] = e[DW-1:0];
      wr_seen++;
    end else begin
      for (int k = 0; k < BL; k++) begin
        d = mem.exists({a, 4'(k)}) ? mem[{a, 4'(k)}] : '0;
        if (rd_seen == corrupt_burst && k == BL - 1) d[5] = ~d[5];
        rx_q.push_back(d);
      end
      rd_seen++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    trace_ready_i = ($urandom_range(0, 99) < ready_pct);
    start_i       = hammer && (wr_seen < NB * BL);
    base_addr_i   = AW'($urandom);
    if (rx_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      trace_v_i    = 1'b1;
      trace_data_i = rx_q[0];
    end else begin
      trace_v_i    = 1'b0;
      trace_data_i = {$urandom, $urandom, $urandom, $urandom};
    end
    #1;
    if (prev_stall) chk("stall_hold", trace_data_o, prev_dat);
    prev_stall = trace_v_o && !trace_ready_i;
    prev_dat   = trace_data_o;
    if (trace_v_o && trace_ready_i) begin
      got_q.push_back(trace_data_o);
      model_accept(trace_data_o);
    end
    if (trace_yumi_o) begin
      void'(rx_q.pop_front());
      last_yumi_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic prep(input int pct, input int corrupt);
    got_q.delete();
    rx_q.delete();
    mem.delete();
    wr_seen = 0;
    rd_seen = 0;
    ready_pct = pct;
    corrupt_burst = corrupt;
    hammer = 0;
    prev_stall = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input bit inj);
    @(negedge clk);
    start_i       = 1'b1;
    base_addr_i   = base;
    trace_ready_i = 1'b0;
    trace_v_i     = 1'b0;
`ifdef BSG_DMC_TRACE_PATTERN_ERR_INJECT_EN
    inject_err_i  = inj;
`endif
    #1;
    chk("valid_before_start", EW'(trace_v_o), EW'(0));
  endtask

  task automatic run_test(input string name, input logic [AW-1:0] base, input int pct,
                          input int corrupt, input bit hm, input bit inj);
    int            budget = 0;
    int            idx = 0;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [15:0]   exp_err = (corrupt >= 0 || inj) ? 16'd1 : 16'd0;
    logic [AW-1:0] exp_first = (corrupt >= 0) ? base + AW'(corrupt * STRIDE) : (inj ? base : '0);
    prep(pct, corrupt);
    pulse_start(base, inj);
    hammer = hm;
    step();
    chk({name, ":start_to_valid"}, EW'(trace_v_o), EW'(1));
    chk({name, ":busy"}, EW'(busy_o), EW'(1));
    while (!done_o && budget < 3000) begin
      step();
      budget++;
    end
    chk({name, ":done"}, EW'(done_o), EW'(1));
    chk({name, ":done_latency"}, EW'(cyc - 1 - last_yumi_cyc), EW'(1));
    chk({name, ":entry_count"}, EW'(got_q.size()), EW'(NB * BL + NB));
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < BL; k++) begin
        a = base + AW'(b * STRIDE);
        d = {4{lfsr_word(b * BL + k)}};
        if (inj && b == 0 && k == 0) d[0] = ~d[0];
        if (idx < got_q.size()) chk({name, ":wr_entry"}, got_q[idx], mk_entry(3'd0, a, d));
        idx++;
      end
    end
    for (int b = 0; b < NB; b++) begin
      a = base + AW'(b * STRIDE);
      if (idx < got_q.size()) chk({name, ":rd_entry"}, got_q[idx], mk_entry(3'd1, a, '0));
      idx++;
    end
    chk({name, ":pass"}, EW'(pass_o), EW'(exp_err == 16'd0));
    chk({name, ":err_count"}, EW'(error_count_o), EW'(exp_err));
    chk({name, ":first_err"}, EW'(first_err_addr_o), EW'(exp_first));
    step();
    chk({name, ":done_held"}, EW'(done_o), EW'(1));
  endtask

  task automatic check_all_zero(input string name);
    chk({name, ":data"}, trace_data_o, '0);
    chk({name, ":v"}, EW'(trace_v_o), EW'(0));
    chk({name, ":yumi"}, EW'(trace_yumi_o), EW'(0));
    chk({name, ":busy"}, EW'(busy_o), EW'(0));
    chk({name, ":done"}, EW'(done_o), EW'(0));
    chk({name, ":pass"}, EW'(pass_o), EW'(0));
    chk({name, ":err"}, EW'(error_count_o), EW'(0));
    chk({name, ":first"}, EW'(first_err_addr_o), EW'(0));
  endtask

  initial begin
    int budget;
    int cb;
    logic [AW-1:0] rb;
    reset_n_i = 1'b0;
    start_i = 1'b0;
    base_addr_i = '0;
    trace_ready_i = 1'b0;
    trace_v_i = 1'b1;
    trace_data_i = '0;
    cyc = 0;
    last_yumi_cyc = 0;
`ifdef BSG_DMC_TRACE_PATTERN_ERR_INJECT_EN
    inject_err_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n_i = 1'b1;
    trace_v_i = 1'b0;

    run_test("basic", 28'h100, 100, -1, 0, 0);
    run_test("corrupt_b2", 28'h100, 100, 2, 0, 0);
    run_test("stall30_busy_start", 28'h100, 30, -1, 1, 0);
    run_test("wrap", 28'hFFFFFF8, 70, -1, 0, 0);
    rb = AW'($urandom);
    cb = $urandom_range(0, NB - 1);
    run_test("random", rb, 50, cb, 1, 0);

    // Reset asserted while the read pass is in flight.
    prep(100, -1);
    pulse_start(28'h200, 0);
    budget = 0;
    while (rd_seen < 1 && budget < 200) begin
      step();
      budget++;
    end
    chk("mid_reset:reached_read", EW'(rd_seen >= 1), EW'(1));
    @(negedge clk);
    reset_n_i = 1'b0;
    trace_v_i = 1'b1;
    trace_ready_i = 1'b1;
    start_i = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    reset_n_i = 1'b1;
    prep(100, -1);
    wr_seen = NB * BL;
    repeat (4) step();
    chk("post_reset_idle:busy", EW'(busy_o), EW'(0));
    chk("post_reset_idle:v", EW'(trace_v_o), EW'(0));
    run_test("after_reset", 28'h300, 60, -1, 0, 0);

`ifdef BSG_DMC_TRACE_PATTERN_ERR_INJECT_EN
    run_test("inject", 28'h400, 80, -1, 0, 1);
    run_test("inject_cleared", 28'h400, 100, -1, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
